// File: rtl/am_err_monitor.sv
// am_err_monitor: measures the error of an unsigned 8x8 approximate multiplier.
// For every accepted sample (x, y, z) the exact product P = x*y is formed and
// the error distance ED = |P - z| is accumulated over NSAMP samples.
//
// Optional feature macro: AM_ERR_SQ_EN adds output sum_sq (sum of ED*ED).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a run (honoured in IDLE only)
//   clr             synchronous abort/clear, wins over everything else
//   in_valid        sample valid; accepted when in_valid & in_ready
//   in_ready        high while a run is collecting samples
//   x, y, z         operands and approximate product
//   done            run complete, statistics final
//   n_cnt, err_cnt  accumulated samples / samples with nonzero ED
//   sum_ed, max_ed  sum and maximum of ED
//   sum_sq          sum of ED*ED (only with AM_ERR_SQ_EN)
module am_err_monitor #(
    parameter int unsigned NSAMP = 65536,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         x,
    input  logic [7:0]         y,
    input  logic [15:0]        z,
    output logic               done,
    output logic [CNT_W-1:0]   n_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W+15:0]  sum_ed,
    output logic [15:0]        max_ed
`ifdef AM_ERR_SQ_EN
    ,
    output logic [CNT_W+31:0]  sum_sq
`endif
);

    localparam int unsigned SUM_W = CNT_W + 16;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSAMP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_done;
    logic [CNT_W-1:0]   r_acc_cnt;

    logic               r_v1, r_v2, r_v3;
    logic [7:0]         r_x1, r_y1;
    logic [15:0]        r_z1;
    logic [15:0]        r_ed2, r_ed3;

    logic [CNT_W-1:0]   r_n_cnt;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [SUM_W-1:0]   r_sum_ed;
    logic [15:0]        r_max_ed;

    logic               w_hs;
    logic [15:0]        w_prod;
    logic [15:0]        w_ed;

    assign w_hs   = in_valid & r_in_ready;
    assign w_prod = {8'd0, r_x1} * {8'd0, r_y1};
    assign w_ed   = (w_prod >= r_z1) ? (w_prod - r_z1) : (r_z1 - w_prod);

    // Control FSM: collects NSAMP handshakes, then waits for the pipeline to empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_done     <= 1'b0;
            r_acc_cnt  <= '0;
        end else if (clr) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_done     <= 1'b0;
            r_acc_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b1;
                        r_acc_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_hs) begin
                        r_acc_cnt <= r_acc_cnt + CNT_W'(1);
                        if (r_acc_cnt == LAST_CNT) begin
                            r_state    <= ST_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // A sample in stage 3 is accumulated on this same edge,
                    // so done rises together with the final statistics.
                    if (!r_v1 && !r_v2) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    // Sample pipeline: stage 1 operands, stage 2 ED, stage 3 ED into accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_x1  <= '0;
            r_y1  <= '0;
            r_z1  <= '0;
            r_ed2 <= '0;
            r_ed3 <= '0;
        end else begin
            r_v1  <= w_hs & ~clr;
            r_v2  <= r_v1 & ~clr;
            r_v3  <= r_v2 & ~clr;
            r_x1  <= x;
            r_y1  <= y;
            r_z1  <= z;
            r_ed2 <= w_ed;
            r_ed3 <= r_ed2;
        end
    end

    // Statistics accumulators; cleared on clr and at the start of every run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n_cnt   <= '0;
            r_err_cnt <= '0;
            r_sum_ed  <= '0;
            r_max_ed  <= '0;
        end else if (clr || (r_state == ST_IDLE && start)) begin
            r_n_cnt   <= '0;
            r_err_cnt <= '0;
            r_sum_ed  <= '0;
            r_max_ed  <= '0;
        end else if (r_v3) begin
            r_n_cnt   <= r_n_cnt + CNT_W'(1);
            r_err_cnt <= r_err_cnt + CNT_W'(r_ed3 != 16'd0);
            r_sum_ed  <= r_sum_ed + SUM_W'(r_ed3);
            if (r_ed3 > r_max_ed) begin
                r_max_ed <= r_ed3;
            end
        end
    end

`ifdef AM_ERR_SQ_EN
    localparam int unsigned SQ_W = CNT_W + 32;

    logic [SQ_W-1:0]    r_sum_sq;
    logic [31:0]        w_sq;

    assign w_sq = {16'd0, r_ed3} * {16'd0, r_ed3};

    // Sum of squared ED, same clear/update timing as sum_ed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_sq <= '0;
        end else if (clr || (r_state == ST_IDLE && start)) begin
            r_sum_sq <= '0;
        end else if (r_v3) begin
            r_sum_sq <= r_sum_sq + SQ_W'(w_sq);
        end
    end

    assign sum_sq = r_sum_sq;
`endif

    assign in_ready = r_in_ready;
    assign done     = r_done;
    assign n_cnt    = r_n_cnt;
    assign err_cnt  = r_err_cnt;
    assign sum_ed   = r_sum_ed;
    assign max_ed   = r_max_ed;

endmodule

// File: tb/tb_am_err_monitor.sv
// Bench for am_err_monitor: three instances (NSAMP = 4, 2, 1) share one stimulus
// stream; a sample-list model predicts every output after every clock edge.
module tb_am_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  x = 8'd0;
    logic [7:0]  y = 8'd0;
    logic [15:0] z = 16'd0;

    logic        rdy [3];
    logic        dn  [3];
    logic [31:0] n   [3];
    logic [31:0] e   [3];
    logic [47:0] s   [3];
    logic [15:0] mx  [3];
    logic [63:0] sq  [3];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

`ifdef AM_ERR_SQ_EN
    am_err_monitor #(.NSAMP(4), .CNT_W(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .in_valid(in_valid),
        .in_ready(rdy[0]), .x(x), .y(y), .z(z), .done(dn[0]), .n_cnt(n[0]),
        .err_cnt(e[0]), .sum_ed(s[0]), .max_ed(mx[0]), .sum_sq(sq[0]));
    am_err_monitor #(.NSAMP(2), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .in_valid(in_valid),
        .in_ready(rdy[1]), .x(x), .y(y), .z(z), .done(dn[1]), .n_cnt(n[1]),
        .err_cnt(e[1]), .sum_ed(s[1]), .max_ed(mx[1]), .sum_sq(sq[1]));
    am_err_monitor #(.NSAMP(1), .CNT_W(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .in_valid(in_valid),
        .in_ready(rdy[2]), .x(x), .y(y), .z(z), .done(dn[2]), .n_cnt(n[2]),
        .err_cnt(e[2]), .sum_ed(s[2]), .max_ed(mx[2]), .sum_sq(sq[2]));
`else
    am_err_monitor #(.NSAMP(4), .CNT_W(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .in_valid(in_valid),
        .in_ready(rdy[0]), .x(x), .y(y), .z(z), .done(dn[0]), .n_cnt(n[0]),
        .err_cnt(e[0]), .sum_ed(s[0]), .max_ed(mx[0]));
    am_err_monitor #(.NSAMP(2), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .in_valid(in_valid),
        .in_ready(rdy[1]), .x(x), .y(y), .z(z), .done(dn[1]), .n_cnt(n[1]),
        .err_cnt(e[1]), .sum_ed(s[1]), .max_ed(mx[1]));
    am_err_monitor #(.NSAMP(1), .CNT_W(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .in_valid(in_valid),
        .in_ready(rdy[2]), .x(x), .y(y), .z(z), .done(dn[2]), .n_cnt(n[2]),
        .err_cnt(e[2]), .sum_ed(s[2]), .max_ed(mx[2]));
    initial for (int i = 0; i < 3; i++) sq[i] = 64'd0;
`endif

    // Model: per instance, whether a run is open and the list of accepted
    // samples (ED value, edge index of acceptance).
    int m_edge = 0;
    bit m_act [3];
    int m_acc [3];
    int m_ed  [3][8];
    int m_t   [3][8];

    function automatic int ns(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 1'b0;
            m_acc[i] = 0;
        end
    endtask

    task automatic model_step();
        int p;
        int ed;
        m_edge++;
        if (!rst_n) begin
            model_clear();
            return;
        end
        p  = int'(x) * int'(y);
        ed = (p > int'(z)) ? (p - int'(z)) : (int'(z) - p);
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                m_act[i] = 1'b0;
                m_acc[i] = 0;
            end else if (!m_act[i]) begin
                if (start) begin
                    m_act[i] = 1'b1;
                    m_acc[i] = 0;
                end
            end else if (m_acc[i] < ns(i) && in_valid) begin
                m_ed[i][m_acc[i]] = ed;
                m_t[i][m_acc[i]]  = m_edge;
                m_acc[i]++;
            end
        end
    endtask

    task automatic model_compare();
        longint en, ee, es, emx, esq;
        bit erdy, edn;
        for (int i = 0; i < 3; i++) begin
            en = 0; ee = 0; es = 0; emx = 0; esq = 0;
            for (int j = 0; j < m_acc[i]; j++) begin
                if (m_edge - m_t[i][j] >= 3) begin
                    en++;
                    if (m_ed[i][j] != 0) ee++;
                    es  += m_ed[i][j];
                    esq += longint'(m_ed[i][j]) * longint'(m_ed[i][j]);
                    if (m_ed[i][j] > emx) emx = m_ed[i][j];
                end
            end
            erdy = m_act[i] && (m_acc[i] < ns(i));
            edn  = m_act[i] && (m_acc[i] == ns(i)) && (m_edge - m_t[i][ns(i)-1] >= 3);
            chk($sformatf("u%0d in_ready", i), 64'(rdy[i]), 64'(erdy));
            chk($sformatf("u%0d done", i), 64'(dn[i]), 64'(edn));
            chk($sformatf("u%0d n_cnt", i), 64'(n[i]), 64'(en));
            chk($sformatf("u%0d err_cnt", i), 64'(e[i]), 64'(ee));
            chk($sformatf("u%0d sum_ed", i), 64'(s[i]), 64'(es));
            chk($sformatf("u%0d max_ed", i), 64'(mx[i]), 64'(emx));
`ifdef AM_ERR_SQ_EN
            chk($sformatf("u%0d sum_sq", i), sq[i], 64'(esq));
`endif
        end
    endtask

    always @(negedge rst_n) model_clear();

    // Compare process: model advances on each rising edge, outputs checked 1 ns later.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            model_compare();
        end
    end

    initial begin
        #90000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic zero_chk(input string tag, input int i);
        chk({tag, " in_ready"}, 64'(rdy[i]), 64'd0);
        chk({tag, " done"}, 64'(dn[i]), 64'd0);
        chk({tag, " n_cnt"}, 64'(n[i]), 64'd0);
        chk({tag, " err_cnt"}, 64'(e[i]), 64'd0);
        chk({tag, " sum_ed"}, 64'(s[i]), 64'd0);
        chk({tag, " max_ed"}, 64'(mx[i]), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) zero_chk($sformatf("reset u%0d", i), i);
        rst_n = 1'b1;

        // Exact product run; in_valid high already in IDLE and kept through DRAIN/DONE.
        @(negedge clk); in_valid = 1'b1; x = 8'd255; y = 8'd255; z = 16'd65025;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("nsamp1 in_ready drop", 64'(rdy[2]), 64'd0);
        chk("nsamp4 in_ready kept", 64'(rdy[0]), 64'd1);
        @(negedge clk);
        @(negedge clk); chk("latency n_cnt before N+3", 64'(n[0]), 64'd0);
        @(negedge clk); chk("latency n_cnt after N+3", 64'(n[0]), 64'd1);
        repeat (8) @(negedge clk);
        chk("exact done", 64'(dn[0]), 64'd1);
        chk("exact n_cnt", 64'(n[0]), 64'd4);
        chk("exact err_cnt", 64'(e[0]), 64'd0);
        chk("exact sum_ed", 64'(s[0]), 64'd0);
        chk("exact max_ed", 64'(mx[0]), 64'd0);
        chk("nsamp1 n_cnt", 64'(n[2]), 64'd1);
        chk("nsamp1 done", 64'(dn[2]), 64'd1);
        in_valid = 1'b0;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        for (int i = 0; i < 3; i++) zero_chk($sformatf("clr u%0d", i), i);

        // Two error samples: ED 20000 and 3.
        start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; x = 8'd200; y = 8'd100; z = 16'd0;
        @(negedge clk); x = 8'd3; y = 8'd3; z = 16'd12;
        @(negedge clk); in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("two n_cnt", 64'(n[1]), 64'd2);
        chk("two err_cnt", 64'(e[1]), 64'd2);
        chk("two sum_ed", 64'(s[1]), 64'd20003);
        chk("two max_ed", 64'(mx[1]), 64'd20000);
        chk("two done", 64'(dn[1]), 64'd1);
`ifdef AM_ERR_SQ_EN
        chk("two sum_sq", sq[1], 64'd400000009);
`endif
        chk("mid-run n_cnt", 64'(n[0]), 64'd2);
        chk("mid-run done", 64'(dn[0]), 64'd0);

        // clr together with start and a handshake.
        clr = 1'b1; start = 1'b1; in_valid = 1'b1;
        @(negedge clk); clr = 1'b0; start = 1'b0; in_valid = 1'b0;
        zero_chk("clr priority u0", 0);
        zero_chk("clr priority u1", 1);

        // Asynchronous reset between edges in the middle of a run.
        start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; x = 8'd17; y = 8'd19; z = 16'd300;
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset sum_ed", 64'(s[0]), 64'd23);
        chk("pre-reset in_ready", 64'(rdy[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1 zero_chk("async reset u0", 0);
        #1 rst_n = 1'b1;
        @(negedge clk); in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("post-reset idle n_cnt", 64'(n[0]), 64'd0);
        chk("post-reset idle in_ready", 64'(rdy[0]), 64'd0);

        // Pseudo-random run checked by the model only.
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            x = 8'($urandom);
            y = 8'($urandom);
            z = 16'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1; x = 8'd16; y = 8'd16; z = 16'd250;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("random run done", 64'(dn[0]), 64'd1);
        chk("random run n_cnt", 64'(n[0]), 64'd4);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/am_err_monitor.md
AM_ERR_MONITOR -- requirements
Module: am_err_monitor

Interface
REQ-001 SHALL have parameter NSAMP, default 65536, number of samples per measurement run (legal 1..2^CNT_W-1).
REQ-002 SHALL have parameter CNT_W, default 32, width of the sample counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  begin a run (sampled in IDLE only).
REQ-006 SHALL have port clr  input  1  synchronous abort/clear.
REQ-007 SHALL have port in_valid  input  1  sample valid.
REQ-008 SHALL have port in_ready  output  1  sample accepted when in_valid & in_ready.
REQ-009 SHALL have ports x, y  input  8 each  multiplier operands.
REQ-010 SHALL have port z  input  16  approximate product from the unsigned 8x8 approximate multiplier for x, y.
REQ-011 SHALL have port done  output  1  run complete, statistics final.
REQ-012 SHALL have port n_cnt  output  CNT_W  samples accumulated.
REQ-013 SHALL have port err_cnt  output  CNT_W  samples with nonzero error.
REQ-014 SHALL have port sum_ed  output  16+CNT_W  sum of error distances.
REQ-015 SHALL have port max_ed  output  16  largest error distance seen.

Function
REQ-016 SHALL compute exact product P = x*y (16-bit, unsigned) and error distance ED = |P - z| (16-bit; both P>z and z>P handled).
REQ-017 SHALL pipeline as stage 1 register x, y, z, valid; stage 2 register ED, valid; stage 3 update accumulators; a sample accepted at edge N is reflected in outputs after edge N+3.
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE: in_ready=0; start=1 -> RUN and zero all accumulators and the accepted-sample counter.
REQ-020 RUN: in_ready=1; each handshake increments the accepted count; the handshake taking the count to NSAMP -> DRAIN in the same edge.
REQ-021 DRAIN: in_ready=0; when pipeline holds no valid sample -> DONE.
REQ-022 DONE: done=1, in_ready=0, outputs held until clr; start ignored.
REQ-023 Per accumulated sample: n_cnt += 1; err_cnt += (ED != 0); sum_ed += ED; max_ed = max(max_ed, ED).
REQ-024 clr=1 in any state SHALL on the next edge flush all pipeline valids, zero all outputs/accumulators, go to IDLE; clr wins over start and over a simultaneous handshake.
REQ-025 in_valid while in_ready=0 SHALL be ignored and not counted.
REQ-026 Accumulators SHALL not overflow for legal NSAMP; no saturation logic required.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, clear all pipeline valids and registers, and drive in_ready=0, done=0, n_cnt=0, err_cnt=0, sum_ed=0, max_ed=0.
REQ-028 Reset asserted mid-run SHALL discard the run; after release the block waits in IDLE for start.

Configuration
REQ-029 With AM_ERR_SQ_EN defined, SHALL add output sum_sq  output  32+CNT_W, accumulating ED*ED per sample with the same latency, reset and clr behaviour as sum_ed.
REQ-030 Without AM_ERR_SQ_EN, port sum_sq and the squarer SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset then start, NSAMP=4, samples (255,255,z=65025)x4 -> done after drain, n_cnt=4, err_cnt=0, sum_ed=0, max_ed=0.
REQ-032 NSAMP=2: (200,100,z=0), (3,3,z=12) -> n_cnt=2, err_cnt=2, sum_ed=20003, max_ed=20000; sum_sq=400000009 with AM_ERR_SQ_EN.
REQ-033 Handshake at edge N -> n_cnt changes after edge N+3; in_valid held high in IDLE/DRAIN/DONE -> counts unchanged.
REQ-034 clr asserted together with start and in_valid during RUN after 2 samples -> next cycle IDLE, all outputs 0, done=0.
REQ-035 rst_n pulsed low mid-RUN asynchronously (between edges) -> outputs zero immediately, in_ready=0, IDLE after release.
REQ-036 NSAMP=1 with back-to-back in_valid -> exactly one sample accepted, in_ready drops the following cycle, done within 4 cycles.
